// File: rtl/mult_div_unit.sv
// HI/LO multiply-divide unit: result computed at start, committed after MULT_CYCLES/DIV_CYCLES busy cycles.
// No backpressure; the hazard stage stalls on start|busy, and ops arriving while busy are dropped.
module mult_div_unit #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        flush,
   output logic        start,
   output logic        busy,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic [31:0] out
);
   localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW   = $clog2(MAXC + 1);

   typedef enum logic {IDLE, RUN} state_t;

   state_t        r_state, w_state_nxt;
   logic [CW-1:0] r_cnt, w_cnt_nxt;
   logic [31:0]   r_hi, r_lo, r_pend_hi, r_pend_lo;
   logic          r_pend_we;
   logic          w_commit;

   logic w_is_mult, w_is_div, w_signed, w_idle, w_mthi, w_mtlo;
   assign w_is_mult = (op == 4'b0001) || (op == 4'b0011);
   assign w_is_div  = (op == 4'b0010) || (op == 4'b0100);
   assign w_signed  = (op == 4'b0001) || (op == 4'b0010);
   assign w_idle    = (r_state == IDLE);
   assign w_mthi    = (op == 4'b0111) && !flush && w_idle;
   assign w_mtlo    = (op == 4'b1000) && !flush && w_idle;

   assign start = (w_is_mult || w_is_div) && !flush && w_idle;
   assign busy  = (r_state == RUN);
   assign hi    = r_hi;
   assign lo    = r_lo;
   assign out   = (op == 4'b0101) ? r_hi : (op == 4'b0110) ? r_lo : 32'd0;

   // Divisor forced to 1 when zero so the divider never sees x/0; the result is discarded anyway.
   logic [63:0] w_sprod, w_uprod;
   logic [31:0] w_divisor, w_sq, w_sr, w_uq, w_ur;
   assign w_sprod   = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
   assign w_uprod   = {32'd0, a} * {32'd0, b};
   assign w_divisor = (b == 32'd0) ? 32'd1 : b;
   assign w_sq      = $signed(a) / $signed(w_divisor);
   assign w_sr      = $signed(a) % $signed(w_divisor);
   assign w_uq      = a / w_divisor;
   assign w_ur      = a % w_divisor;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_commit    = 1'b0;
      case (r_state)
         IDLE: begin
            if (start) begin
               w_state_nxt = RUN;
               w_cnt_nxt   = w_is_mult ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
            end
         end
         RUN: begin
            w_cnt_nxt = r_cnt - CW'(1);
            if (r_cnt <= CW'(1)) begin
               w_state_nxt = IDLE;
               w_cnt_nxt   = '0;
               w_commit    = 1'b1;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_pend_hi <= '0;
         r_pend_lo <= '0;
         r_pend_we <= 1'b0;
      end else if (start) begin
         if (w_is_mult) begin
            {r_pend_hi, r_pend_lo} <= w_signed ? w_sprod : w_uprod;
            r_pend_we              <= 1'b1;
         end else begin
            r_pend_hi <= w_signed ? w_sr : w_ur;
            r_pend_lo <= w_signed ? w_sq : w_uq;
            r_pend_we <= (b != 32'd0);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_hi <= '0;
         r_lo <= '0;
      end else if (w_commit) begin
         if (r_pend_we) begin
            r_hi <= r_pend_hi;
            r_lo <= r_pend_lo;
         end
      end else begin
         if (w_mthi) r_hi <= a;
         if (w_mtlo) r_lo <= a;
      end
   end
endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: expected HI/LO and busy length are queued at issue and checked on busy fall.
module tb_mult_div_unit;
   localparam logic [3:0] OP_NONE = 4'b0000, OP_MULT = 4'b0001, OP_MULTU = 4'b0011,
                          OP_DIV = 4'b0010, OP_DIVU = 4'b0100, OP_MFHI = 4'b0101,
                          OP_MFLO = 4'b0110, OP_MTHI = 4'b0111, OP_MTLO = 4'b1000;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [3:0]  op = OP_NONE;
   logic [31:0] a = '0, b = '0;
   logic        flush = 1'b0;
   logic        start, busy;
   logic [31:0] hi, lo, out;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      int          n;
   } exp_t;

   exp_t q[$];
   int   total = 0;
   int   bad = 0;

   mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk(clk), .reset(reset), .op(op), .a(a), .b(b), .flush(flush),
      .start(start), .busy(busy), .hi(hi), .lo(lo), .out(out)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   // Scoreboard monitor: counts busy cycles, compares on the busy falling edge.
   int   busy_cnt = 0;
   logic prev_busy = 1'b0;
   always @(negedge clk) begin
      if (reset) begin
         busy_cnt  = 0;
         prev_busy = 1'b0;
      end else begin
         if (busy) busy_cnt++;
         else if (prev_busy) begin
            if (q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_completion: hi=%h lo=%h", hi, lo);
            end else begin
               exp_t e;
               e = q.pop_front();
               chk("done_hi", hi, e.hi);
               chk("done_lo", lo, e.lo);
               if (e.n >= 0) chk("busy_len", busy_cnt, e.n);
            end
            busy_cnt = 0;
         end
         prev_busy = busy;
      end
   end

   // Op held a second cycle: start must drop once busy, and the repeat must be ignored.
   task automatic issue(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic f, input logic exp_start);
      op = o; a = x; b = y; flush = f;
      @(negedge clk); chk("start", start, exp_start);
      @(posedge clk); #1;
      @(negedge clk); chk("start_hold", start, 1'b0);
      @(posedge clk); #1;
      op = OP_NONE; flush = 1'b0;
   endtask

   task automatic push(input logic [31:0] h, input logic [31:0] l, input int n);
      exp_t e;
      e.hi = h; e.lo = l; e.n = n;
      q.push_back(e);
   endtask

   task automatic wait_done();
      int k;
      for (k = 0; k < 60; k++) begin
         if (q.size() == 0 && !busy) break;
         @(posedge clk); #1;
      end
      total++;
      if (q.size() != 0 || busy) begin
         bad++;
         $display("FAIL timeout: pending=%0d busy=%0b want pending=0 busy=0", q.size(), busy);
         q.delete();
      end
   endtask

   task automatic mt(input logic [3:0] o, input logic [31:0] x);
      op = o; a = x;
      @(posedge clk); #1;
      op = OP_NONE;
   endtask

   task automatic rd(input string nm, input logic [3:0] o, input logic [31:0] exp);
      op = o;
      @(negedge clk); chk(nm, out, exp);
      @(posedge clk); #1;
      op = OP_NONE;
   endtask

   initial begin
      #2;
      chk("rst_busy", busy, 1'b0);
      chk("rst_hi", hi, 32'h0);
      chk("rst_lo", lo, 32'h0);
      chk("rst_start", start, 1'b0);
      chk("rst_out", out, 32'h0);
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;

      push(32'hFFFFFFFF, 32'hFFFFFFFE, 5);
      issue(OP_MULT, 32'hFFFFFFFF, 32'd2, 1'b0, 1'b1);
      wait_done();
      push(32'h00000001, 32'hFFFFFFFE, 5);
      issue(OP_MULTU, 32'hFFFFFFFF, 32'd2, 1'b0, 1'b1);
      wait_done();
      push(32'hFFFFFFFF, 32'hFFFFFFFD, 10);
      issue(OP_DIV, 32'hFFFFFFF9, 32'd2, 1'b0, 1'b1);
      wait_done();
      push(32'd1, 32'd3, 10);
      issue(OP_DIVU, 32'd7, 32'd2, 1'b0, 1'b1);
      wait_done();

      mt(OP_MTHI, 32'h12345678);
      rd("mfhi_after_mthi", OP_MFHI, 32'h12345678);
      push(32'h12345678, 32'd3, 10);
      issue(OP_DIV, 32'd99, 32'd0, 1'b0, 1'b1);
      wait_done();

      issue(OP_MULT, 32'd6, 32'd7, 1'b1, 1'b0);
      repeat (8) @(posedge clk);
      #1;
      chk("flush_busy", busy, 1'b0);
      chk("flush_hi", hi, 32'h12345678);
      chk("flush_lo", lo, 32'd3);

      push(32'd0, 32'd15, 5);
      issue(OP_MULT, 32'd3, 32'd5, 1'b0, 1'b1);
      op = OP_MFHI; flush = 1'b1;
      @(negedge clk);
      chk("mfhi_during_busy", out, 32'h12345678);
      chk("busy_mid", busy, 1'b1);
      @(posedge clk); #1;
      op = OP_NONE; flush = 1'b0;
      wait_done();

      mt(OP_MTLO, 32'hCAFEBABE);
      rd("mflo_after_mtlo", OP_MFLO, 32'hCAFEBABE);

      push(32'd0, 32'd0, -1);
      issue(OP_MULT, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b1);
      #1 reset = 1'b1;
      #1;
      chk("midrst_busy", busy, 1'b0);
      chk("midrst_hi", hi, 32'h0);
      chk("midrst_lo", lo, 32'h0);
      chk("midrst_start", start, 1'b0);
      chk("midrst_out", out, 32'h0);
      #1 reset = 1'b0;
      wait_done();
      repeat (8) @(posedge clk);
      #1;
      chk("postrst_hi", hi, 32'h0);
      chk("postrst_lo", lo, 32'h0);
      chk("postrst_busy", busy, 1'b0);

      push(32'd1, 32'd0, 5);
      issue(OP_MULT, 32'h00010000, 32'h00010000, 1'b0, 1'b1);
      wait_done();
      push(32'd1, 32'hFFFFFFFD, 10);
      issue(OP_DIV, 32'd7, 32'hFFFFFFFE, 1'b0, 1'b1);
      wait_done();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end
endmodule
